// File: rtl/datamem_arbiter_if.sv
// ---------------------------------------------------------------------------
// datamem_arbiter_if
// Bundles the two requester ports of the data-memory arbiter and the wires
// that run to the single-cycle data memory.
//   Requester side : reqN, weN, sizeN, addrN, wdataN (to arbiter)
//                    ackN, errN, rdataN (from arbiter), N = 0 (CPU), 1 (DMA)
//   Status         : busy (from arbiter)
//   Memory side    : mem_address, mem_datain, mem_we, mem_writebyte,
//                    mem_writehalfword (from arbiter), mem_data (to arbiter)
// slave  : the arbiter's view.
// master : the requesters' and memory's view (the environment).
// ---------------------------------------------------------------------------
interface datamem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [1:0]  size0;
    logic [1:0]  size1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic        mem_writebyte;
    logic        mem_writehalfword;
    logic [31:0] mem_data;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1,
               wdata0, wdata1, mem_data,
        output ack0, ack1, err0, err1, rdata0, rdata1, busy,
               mem_address, mem_datain, mem_we, mem_writebyte,
               mem_writehalfword
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1,
               wdata0, wdata1, mem_data,
        input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
               mem_address, mem_datain, mem_we, mem_writebyte,
               mem_writehalfword
    );
endinterface

// File: rtl/datamem_arbiter.sv
// ---------------------------------------------------------------------------
// datamem_arbiter
// Two-port round-robin arbiter/sequencer in front of a single-cycle,
// big-endian data memory (asynchronous read, write on posedge clk).
// One transaction runs at a time through IDLE -> ACCESS -> RESP.
// Commands are range/alignment checked when granted; a failing command never
// writes memory, returns rdata = 0 and completes with err set.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : datamem_arbiter_if.slave (requester ports, busy, memory wires)
// ---------------------------------------------------------------------------
module datamem_arbiter #(
    parameter logic [31:0] STARTADDR = 32'h1000_0000,
    parameter logic [31:0] LENGTH    = 32'h0000_1000
) (
    input logic              clk,
    input logic              reset,
    datamem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Latched command of the granted port
    logic        last_grant_reg;
    logic        port_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;

    logic [31:0] rdata_reg [2];

    // Per-port views of the requester signals so the grant mux can index them
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [1:0]  size_arr  [2];
    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];
    logic [1:0]  ack_vec;

    logic        grant_valid;
    logic        grant_id;
    logic        grant_err;
    logic [31:0] read_value;

    assign req_vec      = {bus.req1, bus.req0};
    assign we_vec       = {bus.we1, bus.we0};
    assign size_arr[0]  = bus.size0;
    assign size_arr[1]  = bus.size1;
    assign addr_arr[0]  = bus.addr0;
    assign addr_arr[1]  = bus.addr1;
    assign wdata_arr[0] = bus.wdata0;
    assign wdata_arr[1] = bus.wdata1;

    // Range and alignment check. The end address is formed in 33 bits so an
    // access near 32'hFFFF_FFFF cannot wrap back into the valid window.
    function automatic logic cmd_check(input logic [1:0] size, input logic [31:0] addr);
        logic [32:0] nbytes;
        logic [32:0] end_addr;
        logic [32:0] limit;
        logic        bad;
        case (size)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        end_addr = {1'b0, addr} + nbytes;
        limit    = {1'b0, STARTADDR} + {1'b0, LENGTH};
        bad      = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (|addr[1:0]))
                 | (addr < STARTADDR)
                 | (end_addr > limit);
        return bad;
    endfunction

    // Round-robin: on a tie the port that did not win last time is granted.
    always_comb begin
        grant_valid = |req_vec;
        grant_id    = 1'b0;
        if (req_vec == 2'b10) begin
            grant_id = 1'b1;
        end else if (req_vec == 2'b11) begin
            grant_id = ~last_grant_reg;
        end
    end

    assign grant_err = cmd_check(size_arr[grant_id], addr_arr[grant_id]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- command latch ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            err_reg        <= 1'b0;
        end else if ((state_reg == IDLE) && grant_valid) begin
            last_grant_reg <= grant_id;
            port_reg       <= grant_id;
            we_reg         <= we_vec[grant_id];
            size_reg       <= size_arr[grant_id];
            addr_reg       <= addr_arr[grant_id];
            wdata_reg      <= wdata_arr[grant_id];
            err_reg        <= grant_err;
        end
    end

    // ---------------- memory drive ----------------
    // Only ACCESS touches the memory; the write lands on the edge ending it.
    // reset gates mem_we directly so a reset during ACCESS blocks the write.
    always_comb begin
        bus.mem_address       = 32'h0;
        bus.mem_datain        = 32'h0;
        bus.mem_we            = 1'b0;
        bus.mem_writebyte     = 1'b0;
        bus.mem_writehalfword = 1'b0;
        if (state_reg == ACCESS) begin
            bus.mem_address       = addr_reg;
            bus.mem_datain        = wdata_reg;
            bus.mem_writebyte     = (size_reg == 2'b00);
            bus.mem_writehalfword = (size_reg == 2'b01);
            bus.mem_we            = we_reg & ~err_reg & ~reset;
        end
    end

    // Big-endian: the addressed byte sits in mem_data[31:24].
    always_comb begin
        read_value = 32'h0;
        if (!err_reg && !we_reg) begin
            case (size_reg)
                2'b00:   read_value = {24'h0, bus.mem_data[31:24]};
                2'b01:   read_value = {16'h0, bus.mem_data[31:16]};
                default: read_value = bus.mem_data;
            endcase
        end
    end

    // ---------------- per-port response ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg[gi] <= 32'h0;
                end else if ((state_reg == ACCESS) && (port_reg == 1'(gi))) begin
                    rdata_reg[gi] <= read_value;
                end
            end
            assign ack_vec[gi] = (state_reg == RESP) && (port_reg == 1'(gi)) && !reset;
        end
    endgenerate

    assign bus.ack0   = ack_vec[0];
    assign bus.ack1   = ack_vec[1];
    assign bus.err0   = ack_vec[0] & err_reg;
    assign bus.err1   = ack_vec[1] & err_reg;
    assign bus.rdata0 = rdata_reg[0];
    assign bus.rdata1 = rdata_reg[1];
    assign bus.busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_datamem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_datamem_arbiter
// Drives datamem_arbiter through directed and randomized transactions, with
// a byte-array memory attached to the memory wires. A separate byte-array
// reference model computes expected err/rdata/memory contents directly from
// the access rules (alignment by modulo, range by arithmetic).
// ---------------------------------------------------------------------------
module tb_datamem_arbiter;

    localparam logic [31:0] START = 32'h1000_0000;
    localparam logic [31:0] LEN   = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;

    datamem_arbiter_if bus ();

    datamem_arbiter #(
        .STARTADDR(START),
        .LENGTH   (LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- memory attached to the DUT ----------------
    bit [7:0] mem_bytes [0:4095];

    function automatic logic [31:0] mem_off(input int k);
        return bus.mem_address - START + 32'(k);
    endfunction

    function automatic int wr_nb();
        if (bus.mem_writebyte) return 1;
        if (bus.mem_writehalfword) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] wr_byte(input int k);
        int nb;
        nb = wr_nb();
        if (k >= nb) return 8'h0;
        return bus.mem_datain[8*(nb-1-k) +: 8];
    endfunction

    always_comb begin
        bus.mem_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (mem_off(k) < LEN)
                bus.mem_data[31-8*k -: 8] = mem_bytes[mem_off(k)];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (k < wr_nb() && mem_off(k) < LEN)
                    mem_bytes[mem_off(k)] <= wr_byte(k);
            end
        end
    end

    // ---------------- reference model ----------------
    bit [7:0]    ref_mem [0:4095];
    logic [31:0] exp_rdata [2];

    function automatic int ref_nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        longint unsigned ea;
        int nb;
        ea = a;
        nb = ref_nb(sz);
        if (sz == 2'd3) return 1'b1;
        if ((ea % nb) != 0) return 1'b1;
        if (ea < START) return 1'b1;
        if (ea + nb > longint'(START) + longint'(LEN)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] off;
        v = 32'h0;
        off = a - START;
        for (int k = 0; k < ref_nb(sz); k++) v = (v << 8) | 32'(ref_mem[off + 32'(k)]);
        return v;
    endfunction

    task automatic ref_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] off;
        int nb;
        off = a - START;
        nb = ref_nb(sz);
        for (int k = 0; k < nb; k++) ref_mem[off + 32'(k)] = wd[8*(nb-1-k) +: 8];
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_image(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 4096; i++) if (mem_bytes[i] != ref_mem[i]) diff++;
        check(tag, 32'(diff), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
    endtask

    // One transaction on port p from an idle arbiter: grant on the first
    // edge, ack visible after the second edge.
    task automatic do_txn(input bit p, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit          e_err;
        logic [31:0] e_rd;
        int          edges;
        int          we_cnt;
        bit          got;
        logic [31:0] obs_err;
        logic [31:0] obs_rd;
        logic [31:0] obs_other;
        logic [31:0] obs_oack;

        e_err = ref_err(sz, a);
        e_rd  = (e_err || w) ? 32'h0 : ref_read(sz, a);
        if (!e_err && w) ref_write(sz, a, wd);

        @(posedge clk);
        #1;
        if (!p) begin
            bus.we0 = w; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
        end else begin
            bus.we1 = w; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
        end

        edges = 0; we_cnt = 0; got = 1'b0;
        while (!got && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.mem_we) we_cnt++;
            got = p ? bus.ack1 : bus.ack0;
        end

        obs_err   = 32'(p ? bus.err1 : bus.err0);
        obs_rd    = p ? bus.rdata1 : bus.rdata0;
        obs_other = p ? bus.rdata0 : bus.rdata1;
        obs_oack  = 32'(p ? bus.ack0 : bus.ack1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        check({tag, "_ack"}, 32'(got), 32'd1);
        if (got) begin
            exp_rdata[p] = e_rd;
            check({tag, "_latency"}, 32'(edges), 32'd2);
            check({tag, "_err"}, obs_err, 32'(e_err));
            check({tag, "_rdata"}, obs_rd, e_rd);
            check({tag, "_other_rdata"}, obs_other, exp_rdata[~p]);
            check({tag, "_other_ack"}, obs_oack, 32'd0);
            check({tag, "_we_cycles"}, 32'(we_cnt), (w && !e_err) ? 32'd1 : 32'd0);
        end
        $display("txn %s port=%0d we=%0d size=%0d addr=%h wdata=%h err=%0d rdata=%h",
                 tag, p, w, sz, a, wd, obs_err, obs_rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          ack_n;
        int          exp_edge;
        bit          ack_port;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          w;
        bit          p;
        int          r;

        reset = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.size0 = 2'b00; bus.addr0 = 32'h0; bus.wdata0 = 32'h0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.size1 = 2'b00; bus.addr1 = 32'h0; bus.wdata1 = 32'h0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;

        // Reset state
        apply_reset();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_err0", 32'(bus.err0), 32'd0);
        check("rst_err1", 32'(bus.err1), 32'd0);
        check("rst_rdata0", bus.rdata0, 32'h0);
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_address", bus.mem_address, 32'h0);

        // Port 0 word write / read back
        do_txn(1'b0, 1'b1, 2'd2, 32'h1000_0010, 32'hDEAD_BEEF, "p0_wr_word");
        do_txn(1'b0, 1'b0, 2'd2, 32'h1000_0010, 32'h0, "p0_rd_word");
        check("p0_rd_word_value", bus.rdata0, 32'hDEAD_BEEF);

        // Port 1 byte write, halfword read
        do_txn(1'b1, 1'b1, 2'd0, 32'h1000_0011, 32'h0000_00A5, "p1_wr_byte");
        do_txn(1'b1, 1'b0, 2'd1, 32'h1000_0010, 32'h0, "p1_rd_half");
        check("p1_rd_half_value", bus.rdata1, 32'h0000_DEA5);
        check("p1_rd_half_p0_hold", bus.rdata0, 32'hDEAD_BEEF);

        // Both ports requesting continuously from reset: grants alternate
        reset = 1'b1;
        bus.we0 = 1'b0; bus.size0 = 2'd2; bus.addr0 = 32'h1000_0010; bus.req0 = 1'b1;
        bus.we1 = 1'b0; bus.size1 = 2'd1; bus.addr1 = 32'h1000_0012; bus.req1 = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        ack_n = 0;
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk);
            #1;
            if (bus.ack0 || bus.ack1) begin
                exp_edge = 2 + 3 * ack_n;
                ack_port = bus.ack1;
                check("rr_ack_edge", 32'(e), 32'(exp_edge));
                check("rr_ack_port", 32'(ack_port), 32'(ack_n % 2));
                check("rr_single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (ack_n % 2 == 0) begin
                    exp_rdata[0] = ref_read(2'd2, 32'h1000_0010);
                    check("rr_rdata0", bus.rdata0, exp_rdata[0]);
                end else begin
                    exp_rdata[1] = ref_read(2'd1, 32'h1000_0012);
                    check("rr_rdata1", bus.rdata1, exp_rdata[1]);
                end
                $display("txn rr ack port=%0d edge=%0d", ack_port, e);
                ack_n++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("rr_ack_count", 32'(ack_n), 32'd9);

        // Alignment / end-of-range
        do_txn(1'b0, 1'b1, 2'd2, 32'h1000_0002, 32'h1234_5678, "misaligned_word");
        do_txn(1'b1, 1'b1, 2'd1, 32'h1000_0FFF, 32'h0000_ABCD, "misaligned_half");
        do_txn(1'b0, 1'b1, 2'd2, 32'h1000_0FFC, 32'hCAFE_F00D, "last_word");

        // Out of range and reserved size
        do_txn(1'b1, 1'b1, 2'd2, 32'h0FFF_FFFC, 32'h5555_5555, "below_start");
        do_txn(1'b0, 1'b1, 2'd2, 32'h1000_1000, 32'h6666_6666, "past_end");
        do_txn(1'b1, 1'b0, 2'd3, 32'h1000_0010, 32'h0, "size_reserved");
        check_image("err_mem_image");

        // Reset during ACCESS
        do_txn(1'b0, 1'b1, 2'd2, 32'h1000_0020, 32'h1111_1111, "pre_abort_wr");
        @(posedge clk);
        #1;
        bus.we0 = 1'b1; bus.size0 = 2'd2; bus.addr0 = 32'h1000_0020; bus.wdata0 = 32'h2222_2222;
        bus.req0 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_access", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        reset = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ack0", 32'(bus.ack0), 32'd0);
        check("abort_rdata0", bus.rdata0, 32'h0);
        @(posedge clk);
        #1;
        check("abort_no_late_ack", 32'(bus.ack0), 32'd0);
        check("abort_mem_word", {mem_bytes[32], mem_bytes[33], mem_bytes[34], mem_bytes[35]},
              32'h1111_1111);
        $display("txn abort port=0 addr=10000020 mem=%h", {mem_bytes[32], mem_bytes[33], mem_bytes[34], mem_bytes[35]});

        // Randomized single-port transactions
        for (int i = 0; i < 60; i++) begin
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            sz = (r < 7) ? 2'(r % 3) : 2'd3;
            case ($urandom_range(0, 7))
                0:       a = START - 32'($urandom_range(1, 8));
                1:       a = START + LEN - 32'($urandom_range(0, 8));
                default: a = START + 32'($urandom_range(0, 63));
            endcase
            do_txn(p, w, sz, a, $urandom, "rand");
        end
        check_image("final_mem_image");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
